// File: rtl/reg_op_datapath_if.sv
// Control-unit side of reg_op_datapath: decoded op request, direct load path, debug read and status.
interface reg_op_datapath_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              start;
  logic [3:0]        op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rc;
  logic              ld_en;
  logic [REG_AW-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
    input  rd_data, hi, lo, busy, done, err
  );

  modport slave (
    input  start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
    output rd_data, hi, lo, busy, done, err
  );
endinterface

// File: rtl/reg_op_datapath.sv
// One register-to-register ALU op per start/done handshake (T1 Y load, T2 Z load, T3 writeback); R0_ZERO_EN hard-wires R0 to 0.
// Latency: busy for 3 cycles after the accepting edge, done/err the cycle after; start while busy is dropped, never queued.
module reg_op_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic              clk,
  input logic              rst_n,
  reg_op_datapath_if.slave cu
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int SH_W   = $clog2(DATA_W);

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y;
  logic [2*DATA_W-1:0] z;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [3:0]          op_q;
  logic [REG_AW-1:0]   ra_q;
  logic [REG_AW-1:0]   rb_q;
  logic [REG_AW-1:0]   rc_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [DATA_W-1:0]   bus_val;
  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   alu_lo;
  logic [2*DATA_W-1:0] alu_z;
  logic                op_legal;
  logic                wb_ok;
  logic                ld_ok;

  // NEG/NOT are unary, so T2 re-reads the first source instead of rc.
  always_comb begin
    bus_val = regs[rb_q];
    if (state == T2 && op_q != OP_NEG && op_q != OP_NOT) bus_val = regs[rc_q];
  end

  always_comb begin
    sh     = bus_val[SH_W-1:0];
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = y + bus_val;
      OP_SUB:  alu_lo = y - bus_val;
      OP_AND:  alu_lo = y & bus_val;
      OP_OR:   alu_lo = y | bus_val;
      OP_SHR:  alu_lo = y >> sh;
      OP_SHRA: alu_lo = $unsigned($signed(y) >>> sh);
      OP_SHL:  alu_lo = y << sh;
      OP_ROR:  alu_lo = DATA_W'({y, y} >> sh);
      OP_ROL:  alu_lo = DATA_W'(({y, y} << sh) >> DATA_W);
      OP_NEG:  alu_lo = {DATA_W{1'b0}} - y;
      OP_NOT:  alu_lo = ~y;
      default: alu_lo = '0;
    endcase
    // Sign-extend both operands to full Z width so the product is signed.
    if (op_q == OP_MUL)
      alu_z = $signed({{DATA_W{y[DATA_W-1]}}, y}) *
              $signed({{DATA_W{bus_val[DATA_W-1]}}, bus_val});
    else
      alu_z = {{DATA_W{1'b0}}, alu_lo};
  end

  assign op_legal = (op_q <= OP_MUL);
  assign wb_ok    = op_legal && (op_q != OP_MUL) && !(R0_ZERO && ra_q == '0);
  assign ld_ok    = cu.ld_en && !(R0_ZERO && cu.ld_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      y      <= '0;
      z      <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_ok) regs[cu.ld_addr] <= cu.ld_data;
          if (cu.start) begin
            op_q   <= cu.op;
            ra_q   <= cu.ra;
            rb_q   <= cu.rb;
            rc_q   <= cu.rc;
            busy_q <= 1'b1;
            state  <= T1;
          end
        end
        T1: begin
          y     <= bus_val;
          state <= T2;
        end
        T2: begin
          z     <= alu_z;
          state <= T3;
        end
        T3: begin
          if (op_q == OP_MUL) begin
            hi_q <= z[2*DATA_W-1:DATA_W];
            lo_q <= z[DATA_W-1:0];
          end else if (wb_ok) begin
            regs[ra_q] <= z[DATA_W-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q  <= !op_legal;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cu.rd_data = regs[cu.rd_addr];
  assign cu.hi      = hi_q;
  assign cu.lo      = lo_q;
  assign cu.busy    = busy_q;
  assign cu.done    = done_q;
  assign cu.err     = err_q;
endmodule

// File: tb/tb_reg_op_datapath.sv
// Directed self-checking bench for reg_op_datapath (DATA_W=32, NUM_REGS=16); inputs driven and outputs sampled on the falling edge.
module tb_reg_op_datapath;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, SHR = 4'd4, SHRA = 4'd5,
                         SHL = 4'd6, ROR = 4'd7, ROL = 4'd8, NEG = 4'd9, NOT_ = 4'd10, MUL = 4'd11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  reg_op_datapath_if #(.DATA_W(32), .REG_AW(4)) cu ();

  reg_op_datapath #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (cu)
  );

  initial forever #5 clk = ~clk;

  task automatic load(input logic [3:0] addr, input logic [31:0] data);
    cu.ld_en = 1'b1; cu.ld_addr = addr; cu.ld_data = data;
    @(negedge clk);
    cu.ld_en = 1'b0;
  endtask

  // Returns at the falling edge inside T1.
  task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    cu.start = 1'b1; cu.op = op; cu.ra = ra; cu.rb = rb; cu.rc = rc;
    @(negedge clk);
    cu.start = 1'b0;
  endtask

  // Returns at the falling edge inside the done cycle.
  task automatic do_op(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    issue(op, ra, rb, rc);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cu.busy, cu.done, cu.err} !== 3'b000) begin
      failures++; $display("FAIL reset_status got=%b exp=000", {cu.busy, cu.done, cu.err});
    end
    checks++;
    if (cu.hi !== 32'h0 || cu.lo !== 32'h0) begin
      failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", cu.hi, cu.lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    load(4'd2, 32'd5);
    load(4'd3, 32'd7);
    issue(ADD, 4'd4, 4'd2, 4'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cu.busy, cu.done} !== 2'b00) begin
      failures++; $display("FAIL reset_mid_t2 busy/done got=%b exp=00", {cu.busy, cu.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (cu.done === 1'b1 || cu.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL reset_abort_activity got=%0d exp=0", pulses);
    end
    for (int i = 0; i < 16; i++) begin
      cu.rd_addr = 4'(i); #1;
      checks++;
      if (cu.rd_data !== 32'h0) begin
        failures++; $display("FAIL reset_reg%0d got=%h exp=0", i, cu.rd_data);
      end
    end
    checks++;
    if (cu.hi !== 32'h0 || cu.lo !== 32'h0) begin
      failures++; $display("FAIL reset_abort_hilo got=%h/%h exp=0/0", cu.hi, cu.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    load(4'd2, 32'd5);
    load(4'd3, 32'd7);
    cu.rd_addr = 4'd2; #1;
    checks++;
    if (cu.rd_data !== 32'd5) begin
      failures++; $display("FAIL add_load_r2 got=%h exp=5", cu.rd_data);
    end
    @(negedge clk);
    issue(ADD, 4'd4, 4'd2, 4'd3);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({cu.busy, cu.done} !== 2'b10) begin
        failures++; $display("FAIL add_busy_t%0d busy/done got=%b exp=10", c, {cu.busy, cu.done});
      end
      if (c == 3) begin
        cu.rd_addr = 4'd4; #1;
        checks++;
        if (cu.rd_data !== 32'd0) begin
          failures++; $display("FAIL add_r4_before_wb got=%h exp=0", cu.rd_data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({cu.busy, cu.done, cu.err} !== 3'b010) begin
      failures++; $display("FAIL add_done busy/done/err got=%b exp=010", {cu.busy, cu.done, cu.err});
    end
    cu.rd_addr = 4'd4; #1;
    checks++;
    if (cu.rd_data !== 32'd12) begin
      failures++; $display("FAIL add_r4 got=%h exp=0000000c", cu.rd_data);
    end
    @(negedge clk);
    checks++;
    if (cu.done !== 1'b0) begin
      failures++; $display("FAIL add_done_width got=%b exp=0", cu.done);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [9] = '{SUB, AND_, OR_, SHR, SHL, ROR, NEG, NOT_, ADD};
    logic [3:0]  rbs [9] = '{4'd2, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd2, 4'd10, 4'd10};
    logic [3:0]  rcs [9] = '{4'd3, 4'd11, 4'd11, 4'd12, 4'd12, 4'd12, 4'd10, 4'd11, 4'd11};
    logic [31:0] exps[9] = '{32'hFFFFFFFE, 32'h00F00034, 32'hFFF012FF, 32'h0F0F0123, 32'h0F012340,
                             32'h4F0F0123, 32'hFFFFFFFB, 32'h0F0FEDCB, 32'h00E01333};
    load(4'd10, 32'hF0F01234);
    load(4'd11, 32'h0FF000FF);
    load(4'd12, 32'd4);
    for (int i = 0; i < 9; i++) begin
      do_op(ops[i], 4'd13, rbs[i], rcs[i]);
      cu.rd_addr = 4'd13; #1;
      checks++;
      if (cu.done !== 1'b1 || cu.rd_data !== exps[i]) begin
        failures++; $display("FAIL alu_op%0d done=%b got=%h exp=%h", ops[i], cu.done, cu.rd_data, exps[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (cu.hi !== 32'h0 || cu.lo !== 32'h0) begin
      failures++; $display("FAIL alu_hilo_untouched got=%h/%h exp=0/0", cu.hi, cu.lo);
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [5] = '{SHRA, ROL, SHL, ROR, SHR};
    logic [3:0]  rcs [5] = '{4'd6, 4'd8, 4'd9, 4'd6, 4'd6};
    logic [31:0] exps[5] = '{32'hC0000000, 32'h00000003, 32'h80000001, 32'hC0000000, 32'h40000000};
    load(4'd5, 32'h80000001);
    load(4'd6, 32'd33);
    load(4'd8, 32'd1);
    load(4'd9, 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], 4'd7, 4'd5, rcs[i]);
      cu.rd_addr = 4'd7; #1;
      checks++;
      if (cu.rd_data !== exps[i]) begin
        failures++; $display("FAIL shift_op%0d got=%h exp=%h", ops[i], cu.rd_data, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    load(4'd1, 32'hFFFFFFFE);
    load(4'd2, 32'd3);
    load(4'd5, 32'h00001234);
    do_op(MUL, 4'd5, 4'd1, 4'd2);
    checks++;
    if (cu.done !== 1'b1 || cu.err !== 1'b0 || cu.hi !== 32'hFFFFFFFF || cu.lo !== 32'hFFFFFFFA) begin
      failures++; $display("FAIL mul_neg done=%b err=%b hi=%h lo=%h exp 1 0 ffffffff fffffffa", cu.done, cu.err, cu.hi, cu.lo);
    end
    cu.rd_addr = 4'd5; #1;
    checks++;
    if (cu.rd_data !== 32'h00001234) begin
      failures++; $display("FAIL mul_ra_untouched got=%h exp=00001234", cu.rd_data);
    end
    @(negedge clk);
    do_op(MUL, 4'd5, 4'd1, 4'd1);
    checks++;
    if (cu.hi !== 32'h0 || cu.lo !== 32'd4) begin
      failures++; $display("FAIL mul_negneg hi=%h lo=%h exp=00000000/00000004", cu.hi, cu.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_op(4'd13, 4'd4, 4'd2, 4'd3);
    checks++;
    if ({cu.done, cu.err} !== 2'b11) begin
      failures++; $display("FAIL illegal_done_err got=%b exp=11", {cu.done, cu.err});
    end
    cu.rd_addr = 4'd4; #1;
    checks++;
    if (cu.rd_data !== 32'd12 || cu.hi !== 32'h0 || cu.lo !== 32'd4) begin
      failures++; $display("FAIL illegal_no_write r4=%h hi=%h lo=%h exp 0000000c 0 4", cu.rd_data, cu.hi, cu.lo);
    end
    @(negedge clk);
    checks++;
    if (cu.err !== 1'b0) begin
      failures++; $display("FAIL illegal_err_width got=%b exp=0", cu.err);
    end
    do_op(4'd15, 4'd1, 4'd1, 4'd1);
    cu.rd_addr = 4'd1; #1;
    checks++;
    if (cu.err !== 1'b1 || cu.rd_data !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL illegal_op15 err=%b r1=%h exp 1 fffffffe", cu.err, cu.rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_ld_busy();
    issue(ADD, 4'd6, 4'd3, 4'd3);
    cu.ld_en = 1'b1; cu.ld_addr = 4'd3; cu.ld_data = 32'h99;
    @(negedge clk);
    cu.start = 1'b1; cu.op = SUB; cu.ra = 4'd7; cu.rb = 4'd3; cu.rc = 4'd3;
    repeat (2) @(negedge clk);
    cu.start = 1'b0; cu.ld_en = 1'b0;
    checks++;
    if (cu.done !== 1'b1) begin
      failures++; $display("FAIL busy_ld_done got=%b exp=1", cu.done);
    end
    cu.rd_addr = 4'd6; #1;
    checks++;
    if (cu.rd_data !== 32'd14) begin
      failures++; $display("FAIL busy_ld_result got=%h exp=0000000e", cu.rd_data);
    end
    cu.rd_addr = 4'd3; #1;
    checks++;
    if (cu.rd_data !== 32'd7) begin
      failures++; $display("FAIL busy_ld_ignored got=%h exp=00000007", cu.rd_data);
    end
    @(negedge clk);
    checks++;
    if (cu.busy !== 1'b0) begin
      failures++; $display("FAIL busy_start_not_queued busy got=%b exp=0", cu.busy);
    end
  endtask

  task automatic test_load_start();
    cu.ld_en = 1'b1; cu.ld_addr = 4'd2; cu.ld_data = 32'd9;
    do_op(ADD, 4'd8, 4'd2, 4'd2);
    cu.ld_en = 1'b0;
    cu.rd_addr = 4'd8; #1;
    checks++;
    if (cu.rd_data !== 32'd18) begin
      failures++; $display("FAIL load_start_sum got=%h exp=00000012", cu.rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    load(4'd1, 32'd1);
    cu.start = 1'b1; cu.op = ADD; cu.ra = 4'd1; cu.rb = 4'd1; cu.rc = 4'd1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (cu.busy !== 1'b1) begin
        failures++; $display("FAIL b2b_accept%0d busy got=%b exp=1", k, cu.busy);
      end
      repeat (3) @(negedge clk);
      if (k == 3) cu.start = 1'b0;
      cu.rd_addr = 4'd1; #1;
      checks++;
      if (cu.done !== 1'b1 || cu.rd_data !== (32'd1 << k)) begin
        failures++; $display("FAIL b2b_op%0d done=%b r1=%h exp 1 %h", k, cu.done, cu.rd_data, 32'd1 << k);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cu.busy !== 1'b0 || cu.rd_data !== 32'd8) begin
      failures++; $display("FAIL b2b_stop busy=%b r1=%h exp 0 00000008", cu.busy, cu.rd_data);
    end
  endtask

  task automatic test_r0();
    logic [31:0] exp_sum, exp_ld;
`ifdef R0_ZERO_EN
    exp_sum = 32'd0; exp_ld = 32'd0;
`else
    exp_sum = 32'd14; exp_ld = 32'h77;
`endif
    do_op(ADD, 4'd0, 4'd3, 4'd3);
    cu.rd_addr = 4'd0; #1;
    checks++;
    if (cu.done !== 1'b1 || cu.rd_data !== exp_sum) begin
      failures++; $display("FAIL r0_add done=%b r0=%h exp 1 %h", cu.done, cu.rd_data, exp_sum);
    end
    @(negedge clk);
    load(4'd0, 32'h77);
    #1;
    checks++;
    if (cu.rd_data !== exp_ld) begin
      failures++; $display("FAIL r0_load got=%h exp=%h", cu.rd_data, exp_ld);
    end
    @(negedge clk);
  endtask

  initial begin
    cu.start = 1'b0; cu.op = '0; cu.ra = '0; cu.rb = '0; cu.rc = '0;
    cu.ld_en = 1'b0; cu.ld_addr = '0; cu.ld_data = '0; cu.rd_addr = '0;
    test_reset();
    test_add();
    test_alu_ops();
    test_shifts();
    test_mul();
    test_illegal();
    test_ld_busy();
    test_load_start();
    test_back_to_back();
    test_r0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
